// File: rtl/sal_cfg_regfile.sv
// sal_cfg_regfile: APB-programmable DDR2 timing register file.
// Software fills NUM_SET shadow timing sets, then requests a commit; the
// selected set is copied into the active timing outputs only while the
// controller is idle, so timing never changes under an in-flight command.
// Reset values come from the T_*_VALUE macros. A project-wide
// SAL_DDR2_PARAMS.svh compiled ahead of this file overrides the fallbacks below.

`ifndef T_RCD_VALUE
`define T_RCD_VALUE 4
`endif
`ifndef T_RP_VALUE
`define T_RP_VALUE 4
`endif
`ifndef T_RAS_VALUE
`define T_RAS_VALUE 12
`endif
`ifndef T_RFC_VALUE
`define T_RFC_VALUE 51
`endif
`ifndef T_RTP_VALUE
`define T_RTP_VALUE 2
`endif
`ifndef T_WTP_VALUE
`define T_WTP_VALUE 8
`endif
`ifndef T_RRD_VALUE
`define T_RRD_VALUE 3
`endif
`ifndef T_CCD_VALUE
`define T_CCD_VALUE 2
`endif
`ifndef T_WTR_VALUE
`define T_WTR_VALUE 3
`endif
`ifndef T_RTW_VALUE
`define T_RTW_VALUE 4
`endif

module sal_cfg_regfile #(
    parameter int NUM_SET = 4,
    parameter int TW      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             psel_i,
    input  logic             penable_i,
    input  logic             pwrite_i,
    input  logic [11:0]      paddr_i,
    input  logic [31:0]      pwdata_i,
    output logic             pready_o,
    output logic [31:0]      prdata_o,
    output logic             pslverr_o,
    input  logic             ctrl_idle_i,
    output logic [10*TW-1:0] timing_o,
    output logic [3:0]       active_set_o,
    output logic             commit_pending_o,
    output logic             commit_done_o
);

    localparam int NF = 10;
    localparam int unsigned DEF_VAL [NF] = '{
        `T_RCD_VALUE, `T_RP_VALUE, `T_RAS_VALUE, `T_RFC_VALUE, `T_RTP_VALUE,
        `T_WTP_VALUE, `T_RRD_VALUE, `T_CCD_VALUE, `T_WTR_VALUE, `T_RTW_VALUE
    };

    logic [TW-1:0] shadow_q [NUM_SET][NF];
    logic [TW-1:0] active_q [NF];
    logic [3:0]    sel_q;
    logic [3:0]    active_set_q;
    logic          pending_q;
    logic          done_q;
    logic [7:0]    count_q;
    logic          rd_wait_q;
    logic          rd_err_q;
    logic [31:0]   prdata_q;

    logic          access;
    logic          wr_acc;
    logic          rd_first;
    logic          rd_last;
    logic [11:0]   off;
    int            s_idx;
    int            f_idx;
    logic          is_ctrl;
    logic          is_status;
    logic          is_shadow;
    logic [TW-1:0] shadow_rd;
    logic [3:0]    sel_new;
    logic          wr_err;
    logic          rd_err;
    logic [31:0]   rd_data;
    logic          ctrl_we;
    logic          shadow_we;
    logic          apply;
    logic          unused_ok;

    assign access   = psel_i & penable_i;
    assign wr_acc   = access & pwrite_i;
    assign rd_first = access & ~pwrite_i & ~rd_wait_q;
    assign rd_last  = access & ~pwrite_i & rd_wait_q;
    assign sel_new  = pwdata_i[7:4];
    assign apply    = pending_q & ctrl_idle_i;

    // Address decode: CTRL, STATUS, or shadow field (set s, field f).
    always_comb begin
        off       = paddr_i - 12'h100;
        s_idx     = int'(off[11:6]);
        f_idx     = int'(off[5:2]);
        is_ctrl   = (paddr_i[11:2] == 10'd0);
        is_status = (paddr_i[11:2] == 10'd1);
        is_shadow = (paddr_i >= 12'h100) && (s_idx < NUM_SET) && (f_idx < NF);
    end

    // Shadow read mux for the addressed field.
    always_comb begin
        shadow_rd = '0;
        for (int s = 0; s < NUM_SET; s++) begin
            for (int f = 0; f < NF; f++) begin
                if (s == s_idx && f == f_idx) begin
                    shadow_rd = shadow_q[s][f];
                end
            end
        end
    end

    // Error classification and read data; a rejected access never changes state.
    always_comb begin
        wr_err  = 1'b1;
        rd_err  = !(is_ctrl || is_status || is_shadow);
        rd_data = '0;
        if (is_ctrl) begin
            // SEL may not move under a pending commit; re-requesting the same set is harmless.
            wr_err  = (int'(sel_new) >= NUM_SET) || (pending_q && (sel_new != sel_q));
            rd_data = {24'd0, sel_q, 3'd0, pending_q};
        end else if (is_status) begin
            rd_data = {16'd0, count_q, 7'd0, pending_q};
        end else if (is_shadow) begin
            wr_err  = (pwdata_i[TW-1:0] == '0) || ((pwdata_i >> TW) != 32'd0) || pending_q;
            rd_data = 32'(shadow_rd);
        end
    end

    assign ctrl_we   = wr_acc & is_ctrl & ~wr_err;
    assign shadow_we = wr_acc & is_shadow & ~wr_err;

    assign pready_o  = wr_acc | rd_last;
    assign pslverr_o = wr_acc ? wr_err : (rd_last & rd_err_q);
    assign prdata_o  = prdata_q;

    // Read path: capture data in the first ACCESS cycle, present it in the second.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_wait_q <= 1'b0;
            rd_err_q  <= 1'b0;
            prdata_q  <= '0;
        end else begin
            rd_wait_q <= rd_first;
            if (rd_first) begin
                rd_err_q <= rd_err;
                prdata_q <= rd_err ? 32'd0 : rd_data;
            end else if (!access) begin
                rd_err_q <= 1'b0;
                prdata_q <= '0;
            end
        end
    end

    // Shadow sets: software writes, blocked while a commit is pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NUM_SET; s++) begin
                for (int f = 0; f < NF; f++) begin
                    shadow_q[s][f] <= DEF_VAL[f][TW-1:0];
                end
            end
        end else if (shadow_we) begin
            for (int s = 0; s < NUM_SET; s++) begin
                for (int f = 0; f < NF; f++) begin
                    if (s == s_idx && f == f_idx) begin
                        shadow_q[s][f] <= pwdata_i[TW-1:0];
                    end
                end
            end
        end
    end

    // Commit control: a request while already pending folds into the existing one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q        <= '0;
            pending_q    <= 1'b0;
            done_q       <= 1'b0;
            count_q      <= '0;
            active_set_q <= '0;
        end else begin
            done_q <= apply;
            if (ctrl_we) begin
                sel_q <= sel_new;
            end
            if (apply) begin
                pending_q    <= 1'b0;
                count_q      <= count_q + 8'd1;
                active_set_q <= sel_q;
            end else if (ctrl_we && pwdata_i[0]) begin
                pending_q <= 1'b1;
            end
        end
    end

    // Active timing: whole-set copy from the selected shadow on apply.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int f = 0; f < NF; f++) begin
                active_q[f] <= DEF_VAL[f][TW-1:0];
            end
        end else if (apply) begin
            for (int s = 0; s < NUM_SET; s++) begin
                if (s == int'(sel_q)) begin
                    for (int f = 0; f < NF; f++) begin
                        active_q[f] <= shadow_q[s][f];
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < NF; g++) begin : g_timing
        assign timing_o[g*TW +: TW] = active_q[g];
    end

    assign active_set_o     = active_set_q;
    assign commit_pending_o = pending_q;
    assign commit_done_o    = done_q;

    assign unused_ok = ^{paddr_i[1:0], off[1:0]};

endmodule

// File: tb/tb_sal_cfg_regfile.sv
// Self-checking bench for sal_cfg_regfile: table-driven APB vectors with a
// scoreboard queue, plus hand sequences for commit, wrap and reset corners.

`ifndef T_RCD_VALUE
`define T_RCD_VALUE 4
`endif
`ifndef T_RP_VALUE
`define T_RP_VALUE 4
`endif
`ifndef T_RAS_VALUE
`define T_RAS_VALUE 12
`endif
`ifndef T_RFC_VALUE
`define T_RFC_VALUE 51
`endif
`ifndef T_RTP_VALUE
`define T_RTP_VALUE 2
`endif
`ifndef T_WTP_VALUE
`define T_WTP_VALUE 8
`endif
`ifndef T_RRD_VALUE
`define T_RRD_VALUE 3
`endif
`ifndef T_CCD_VALUE
`define T_CCD_VALUE 2
`endif
`ifndef T_WTR_VALUE
`define T_WTR_VALUE 3
`endif
`ifndef T_RTW_VALUE
`define T_RTW_VALUE 4
`endif

module tb_sal_cfg_regfile;

    localparam int NUM_SET = 4;
    localparam int TW      = 8;
    localparam int NF      = 10;
    localparam int DEFV [NF] = '{
        `T_RCD_VALUE, `T_RP_VALUE, `T_RAS_VALUE, `T_RFC_VALUE, `T_RTP_VALUE,
        `T_WTP_VALUE, `T_RRD_VALUE, `T_CCD_VALUE, `T_WTR_VALUE, `T_RTW_VALUE
    };

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             psel = 1'b0;
    logic             penable = 1'b0;
    logic             pwrite = 1'b0;
    logic [11:0]      paddr = '0;
    logic [31:0]      pwdata = '0;
    logic             ctrl_idle = 1'b0;
    logic             pready;
    logic [31:0]      prdata;
    logic             pslverr;
    logic [10*TW-1:0] timing;
    logic [3:0]       active_set;
    logic             pending;
    logic             done;

    sal_cfg_regfile #(.NUM_SET(NUM_SET), .TW(TW)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .psel_i           (psel),
        .penable_i        (penable),
        .pwrite_i         (pwrite),
        .paddr_i          (paddr),
        .pwdata_i         (pwdata),
        .pready_o         (pready),
        .prdata_o         (prdata),
        .pslverr_o        (pslverr),
        .ctrl_idle_i      (ctrl_idle),
        .timing_o         (timing),
        .active_set_o     (active_set),
        .commit_pending_o (pending),
        .commit_done_o    (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        bit          err;
    } vec_t;

    typedef struct {
        bit          rd;
        logic [31:0] rdata;
        bit          err;
    } sb_t;

    sb_t              sb_q[$];
    vec_t             vecs[16];
    int               nv = 0;
    int               n_checks = 0;
    int               n_fail = 0;
    int               done_cnt = 0;
    logic [10*TW-1:0] def_timing;
    logic [10*TW-1:0] exp_timing;

    always @(negedge clk) if (done) done_cnt++;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input bit wr, input logic [11:0] a, input logic [31:0] d,
                           input logic [31:0] er, input bit ee);
        vecs[nv].wr    = wr;
        vecs[nv].addr  = a;
        vecs[nv].wdata = d;
        vecs[nv].rdata = er;
        vecs[nv].err   = ee;
        nv++;
    endtask

    task automatic apb(input bit wr, input logic [11:0] a, input logic [31:0] d,
                       input logic [31:0] er, input bit ee);
        sb_t   e;
        int    waits;
        string nm;
        e.rd = !wr;
        e.rdata = er;
        e.err = ee;
        sb_q.push_back(e);
        nm = $sformatf("%s@%03h", wr ? "wr" : "rd", a);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
        @(posedge clk); #1;
        penable = 1'b1;
        #1;
        waits = 0;
        while (!pready && waits < 8) begin
            @(posedge clk); #2;
            waits++;
        end
        if (!pready) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s timeout: pready never rose", nm);
            void'(sb_q.pop_front());
        end else begin
            e = sb_q.pop_front();
            chk({nm, " wait"}, waits, wr ? 0 : 1);
            chk({nm, " err"}, pslverr, e.err);
            if (e.rd) chk({nm, " rdata"}, prdata, e.rdata);
        end
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int f = 0; f < NF; f++) def_timing[f*TW +: TW] = TW'(DEFV[f]);

        add_vec(0, 12'h180, 0, DEFV[0], 0);
        add_vec(0, 12'h000, 0, 32'h0, 0);
        add_vec(0, 12'h004, 0, 32'h0, 0);
        add_vec(1, 12'h1C4, 9, 0, 0);
        add_vec(0, 12'h1C4, 0, 32'd9, 0);
        add_vec(1, 12'h104, 0, 0, 1);
        add_vec(0, 12'h104, 0, DEFV[1], 0);
        add_vec(1, 12'h004, 1, 0, 1);
        add_vec(0, 12'h128, 0, 32'h0, 1);
        add_vec(1, 12'h000, (NUM_SET << 4) | 1, 0, 1);
        add_vec(0, 12'h000, 0, 32'h0, 0);
        add_vec(1, 12'h108, 256, 0, 1);
        add_vec(0, 12'h108, 0, DEFV[2], 0);
        add_vec(0, 12'h200, 0, 32'h0, 1);
        add_vec(0, 12'h008, 0, 32'h0, 1);
        add_vec(1, 12'h124, 32'hFF, 0, 0);

        #12;
        chk("rst timing", timing, def_timing);
        chk("rst active_set", active_set, 0);
        chk("rst pending", pending, 0);
        chk("rst done", done, 0);
        chk("rst pready", pready, 0);
        chk("rst prdata", prdata, 0);
        chk("rst pslverr", pslverr, 0);
        #5 rst_n = 1'b1;

        for (int i = 0; i < nv; i++) begin
            apb(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].rdata, vecs[i].err);
        end
        apb(0, 12'h124, 0, 32'hFF, 0);

        // Commit held off while the controller is busy.
        apb(1, 12'h000, 32'h31, 0, 0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("hold pending", pending, 1);
            chk("hold timing", timing, def_timing);
        end
        apb(0, 12'h000, 0, 32'h31, 0);
        apb(0, 12'h004, 0, 32'h1, 0);
        apb(1, 12'h100, 7, 0, 1);
        apb(0, 12'h100, 0, DEFV[0], 0);
        apb(1, 12'h000, 32'h31, 0, 0);
        apb(1, 12'h000, 32'h21, 0, 1);
        chk("pre-apply done_cnt", done_cnt, 0);
        chk("pre-apply active_set", active_set, 0);

        @(posedge clk); #1;
        ctrl_idle = 1'b1;
        @(posedge clk); #1;
        exp_timing = def_timing;
        exp_timing[1*TW +: TW] = 8'd9;
        chk("apply timing", timing, exp_timing);
        chk("apply active_set", active_set, 3);
        chk("apply done", done, 1);
        chk("apply pending", pending, 0);
        ctrl_idle = 1'b0;
        @(posedge clk); #1;
        chk("done pulse end", done, 0);
        apb(0, 12'h004, 0, 32'h0100, 0);
        chk("single done pulse", done_cnt, 1);

        // 255 further commits wrap the count to zero.
        ctrl_idle = 1'b1;
        for (int i = 0; i < 255; i++) apb(1, 12'h000, 32'h31, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        apb(0, 12'h004, 0, 32'h0000, 0);
        chk("wrap done_cnt", done_cnt, 256);
        ctrl_idle = 1'b0;

        // STATUS read captured on the apply edge returns the pre-apply value.
        apb(1, 12'h000, 32'h31, 0, 0);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 12'h004;
        @(posedge clk); #1;
        penable = 1'b1; ctrl_idle = 1'b1;
        @(posedge clk); #1;
        chk("race pready", pready, 1);
        chk("race status", prdata, 32'h0001);
        chk("race applied", pending, 0);
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; ctrl_idle = 1'b0;
        apb(0, 12'h004, 0, 32'h0100, 0);

        // Reset during a read wait with a commit pending.
        apb(1, 12'h000, 32'h01, 0, 0);
        chk("pre-reset pending", pending, 1);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 12'h1C4;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        chk("mid-read pready", pready, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("reset pready", pready, 0);
        chk("reset prdata", prdata, 0);
        chk("reset pending", pending, 0);
        chk("reset timing", timing, def_timing);
        chk("reset active_set", active_set, 0);
        psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        apb(0, 12'h1C4, 0, DEFV[1], 0);
        apb(0, 12'h004, 0, 32'h0, 0);

        chk("scoreboard empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
